// File: rtl/rv32_imem_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32_imem_fetch_pkg
// Description : Shared rv32 types and constants for the instruction fetch path.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_imem_fetch_pkg;

    typedef logic [31:0] rv32_data_t;
    typedef logic [31:0] rv32_dmem_addr_t;
    typedef logic [31:0] rv32_pc_t;

    typedef struct packed {
        rv32_pc_t   pc;
        rv32_data_t instr;
    } rv32_fetch_entry_t;

    localparam int unsigned RV32_INSTR_BYTES = 4;

    localparam rv32_pc_t c_PC_ALIGN_MASK = 32'hFFFF_FFFC;

    // Instructions are word aligned; the two low PC bits are never meaningful.
    function automatic rv32_pc_t rv32_align_pc(input rv32_pc_t pc);
        return pc & c_PC_ALIGN_MASK;
    endfunction

endpackage : rv32_imem_fetch_pkg
`default_nettype wire

// File: rtl/rv32_imem_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : rv32_imem_fetch_if
// Description : Instruction memory read port plus decode-facing instr stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface rv32_imem_fetch_if
#(
    parameter int ADDR_W = 13
)
();
    import rv32_imem_fetch_pkg::*;

    logic [ADDR_W-1:0] imem_rdaddress;
    rv32_data_t        imem_q;
    logic              instr_valid;
    logic              instr_ready;
    rv32_data_t        instr_data;
    rv32_pc_t          instr_pc;

    // The fetch unit masters both the memory read port and the instr stream.
    modport master (
        output imem_rdaddress,
        input  imem_q,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc
    );

    modport slave (
        input  imem_rdaddress,
        output imem_q,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc
    );

endinterface : rv32_imem_fetch_if
`default_nettype wire

// File: rtl/rv32_fetch_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rv32_fetch_skid_fifo
// Description : 2-entry skid FIFO of {pc, instr} with push/pop/flush.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_fetch_skid_fifo
    import rv32_imem_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
)
(
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              push_i,
    input  wire logic              pop_i,
    input  wire logic              flush_i,
    input  wire rv32_fetch_entry_t din_i,
    output rv32_fetch_entry_t      head_o,
    output logic [1:0]             count_o,
    output logic                   valid_o
);

    localparam int c_CNT_W = 2;

    rv32_fetch_entry_t  slot_q [FIFO_DEPTH];
    rv32_fetch_entry_t  slot_d [FIFO_DEPTH];
    logic [c_CNT_W-1:0] count_q;
    logic [c_CNT_W-1:0] count_d;
    logic [c_CNT_W-1:0] w_kept;
    logic               w_pop_ok;

    assign w_pop_ok = pop_i & (count_q != '0);
    assign w_kept   = count_q - {{(c_CNT_W-1){1'b0}}, w_pop_ok};

    // Slot 0 is always the head; a pop shifts slot 1 down before any push lands.
    always_comb begin
        slot_d  = slot_q;
        count_d = w_kept;
        if (w_pop_ok) begin
            slot_d[0] = slot_q[1];
        end
        if (push_i && (w_kept != c_CNT_W'(FIFO_DEPTH))) begin
            slot_d[w_kept[0]] = din_i;
            count_d           = w_kept + 2'd1;
        end
        if (flush_i) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            slot_q  <= slot_d;
        end
    end

    assign head_o  = slot_q[0];
    assign count_o = count_q;
    assign valid_o = (count_q != '0);

endmodule : rv32_fetch_skid_fifo
`default_nettype wire

// File: rtl/rv32_imem_fetch.sv
`default_nettype none
// ============================================================================
// Module      : rv32_imem_fetch
// Description : Instruction fetch initiator with PC redirect and skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_imem_fetch
    import rv32_imem_fetch_pkg::*;
#(
    parameter rv32_pc_t RESET_PC   = 32'h0000_0000,
    parameter int       ADDR_W     = 13,
    parameter int       FIFO_DEPTH = 2
)
(
    input  wire logic     clock,
    input  wire logic     reset,
    input  wire logic     fetch_en,
    input  wire logic     redirect_valid,
    input  wire rv32_pc_t redirect_pc,
    rv32_imem_fetch_if.master bus
);

    localparam rv32_pc_t c_RESET_PC_ALIGNED = RESET_PC & c_PC_ALIGN_MASK;
    localparam rv32_pc_t c_PC_STEP          = rv32_pc_t'(RV32_INSTR_BYTES);

    rv32_pc_t          fetch_pc_q;
    rv32_pc_t          fetch_pc_d;
    rv32_pc_t          inflight_pc_q;
    rv32_pc_t          inflight_pc_d;
    logic              inflight_q;
    logic              inflight_d;

    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [1:0]        w_count;
    logic [2:0]        w_occ;
    logic              w_fifo_valid;
    rv32_fetch_entry_t w_head;
    rv32_fetch_entry_t w_push_entry;

    assign w_pop  = w_fifo_valid & bus.instr_ready;
    // Slots committed after this edge: buffered + returning read - consumed head.
    assign w_occ  = {1'b0, w_count} + {2'b00, inflight_q} - {2'b00, w_pop};
    assign w_issue = fetch_en & ~redirect_valid & (w_occ < 3'd2);
    assign w_push  = inflight_q & ~redirect_valid;

    assign w_push_entry.pc    = inflight_pc_q;
    assign w_push_entry.instr = bus.imem_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = 1'b0;
        if (redirect_valid) begin
            fetch_pc_d = rv32_align_pc(redirect_pc);
        end else if (w_issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + c_PC_STEP;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q    <= c_RESET_PC_ALIGNED;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    rv32_fetch_skid_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .flush_i (redirect_valid),
        .din_i   (w_push_entry),
        .head_o  (w_head),
        .count_o (w_count),
        .valid_o (w_fifo_valid)
    );

    // Memory reads every cycle from the current PC; only issued reads are kept.
    assign bus.imem_rdaddress = fetch_pc_q[ADDR_W+1:2];
    assign bus.instr_valid    = w_fifo_valid;
    assign bus.instr_data     = w_head.instr;
    assign bus.instr_pc       = w_head.pc;

endmodule : rv32_imem_fetch
`default_nettype wire

// File: doc/rv32_imem_fetch.md
Name: rv32_imem_fetch

Overview:
- Instruction-fetch initiator for the 32 KB instruction memory's read port.
- Drives the word read address, captures the data returned one cycle later, and presents instructions on a valid/ready stream to decode, tagged with their PC.
- A 2-entry skid FIFO absorbs the fixed 1-cycle read latency, so full throughput (1 instr/cycle) is sustained and backpressure is honoured without losing the read data.
- Accepts PC redirects (branch/jump/trap) from the core.

Parameters:
- RESET_PC, 32'h0000_0000, byte PC loaded on reset.
- ADDR_W, 13, word-address width of instruction memory (8192 x 32b).
- FIFO_DEPTH, 2, skid FIFO entries; fixed at 2, other values unsupported.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_en  in  1  1 = allow new reads to issue.
- redirect_valid  in  1  load a new PC this cycle.
- redirect_pc  in  32  target byte PC; bits [1:0] ignored (treated as 0).
- imem_rdaddress  out  ADDR_W  word read address, always equal to fetch_pc[ADDR_W+1:2].
- imem_q  in  32  read data, valid one cycle after the address is sampled.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  consumer accepts the head.
- instr_data  out  32  instruction word at the head.
- instr_pc  out  32  byte PC of instr_data.

Behaviour:
- State:
  - fetch_pc (32b).
  - inflight (1b) and inflight_pc (32b).
  - FIFO of {pc, data} with count 0..2.
- Reset:
  - fetch_pc=RESET_PC with bits [1:0] cleared; inflight=0; count=0.
  - FIFO storage cleared, so instr_valid=0, instr_data=0, instr_pc=0.
  - Reset asserted mid-operation discards the in-flight read and all FIFO entries the same edge.
- pop = instr_valid & instr_ready; the head is removed at that edge.
- issue = fetch_en & ~redirect_valid & (count + inflight - pop < 2).
- On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4. Otherwise inflight<=0.
- Response:
  - If inflight=1 and no redirect this cycle, push {inflight_pc, imem_q} at this edge.
  - Push and pop in the same cycle are both performed.
  - The issue rule guarantees the FIFO never overflows; the bench asserts no push while count=2 without a pop.
- Redirect:
  - Priority over issue, push and FIFO contents.
  - At the edge: fetch_pc<=redirect_pc with [1:0] forced to 0; inflight<=0; count<=0.
  - The in-flight word is discarded, never presented.
  - A head popped in the redirect cycle counts as consumed.
- Latency:
  - Redirect or reset release sampled at edge E0.
  - The new address is on imem_rdaddress after E0, and the read issues at E1.
  - Pushed at E2, so instr_valid=1 after E2 with instr_pc=target. That is 2 cycles.
- Throughput: with instr_ready=1 and fetch_en=1, one instruction per cycle after the initial 2 cycles, PCs strictly +4.
- Backpressure:
  - With instr_ready=0, at most 2 words are buffered; further issue stops.
  - Head data and PC stay stable while valid & ~ready.
- fetch_en=0: no new issue. The in-flight response is still pushed, and buffered entries still drain.
- Wrap-around: fetch_pc+4 is mod 2^32; imem_rdaddress wraps from 8191 to 0 because upper PC bits are not part of the address. instr_pc keeps the full 32-bit value.
- imem_rdaddress is combinational from fetch_pc and free-running. Memory reads every cycle; non-issued reads are ignored.

Decomposition:
- Shared rv32 package:
  - rv32_data_t and rv32_dmem_addr_t (existing).
  - New rv32_pc_t (32b).
  - New rv32_fetch_entry_t packed struct {pc, instr}.
  - Constant RV32_INSTR_BYTES=4.
- One sub-module, rv32_fetch_skid_fifo: 2-entry synchronous FIFO of rv32_fetch_entry_t, with push/pop/flush, count, head output, and synchronous active-high reset.

Test Plan:
- Reset release, RESET_PC=0, ready=1, fetch_en=1, memory word n = n -> instr_valid rises 2 cycles after reset; stream (pc,data) = (0,0),(4,1),(8,2) with no gaps.
- Hold instr_ready=0 for 10 cycles mid-stream -> exactly 2 entries buffered, head stable, no word skipped or duplicated after release; PCs contiguous.
- Redirect to 32'h0000_0103 while 2 entries are buffered and a read is in flight -> old entries and the in-flight word are dropped; next valid is 2 cycles later with instr_pc=32'h100, data=mem[64].
- Redirect to 32'h0000_7FF8 -> PCs 7FF8, 7FFC, 8000; imem_rdaddress 8190, 8191, 0; data mem[0] tagged pc 32'h8000.
- fetch_en deasserted for 5 cycles with ready=1 -> the in-flight word is delivered and the FIFO drains; the stream resumes at the next sequential PC with no loss.
- Reset asserted for 1 cycle with full FIFO and inflight=1 -> instr_valid=0 the next cycle; the fetch restarts at RESET_PC.
